// File: rtl/mac_cluster_param.sv
// mac_cluster_param: NUM_MACS-lane multiply-accumulate tile with a daisy-chained
// serial configuration and a 3-stage stallable pipeline (operand, product, accumulate).
`default_nettype none

module mac_cluster_param #(
    parameter int NUM_MACS       = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = 2 * MAC_MULT_WIDTH,
    parameter int MAC_CONF_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              cen,
    input  logic                              cset,
    input  logic                              shift_in,
    output logic                              shift_out,
    output logic                              cset_out,
    input  logic                              clr,
    input  logic                              in_valid,
    input  logic [NUM_MACS*MAC_MIN_WIDTH-1:0] A,
    input  logic [NUM_MACS*MAC_MIN_WIDTH-1:0] B,
    output logic [NUM_MACS*MAC_ACC_WIDTH-1:0] out,
    output logic                              out_valid,
    output logic [NUM_MACS-1:0]               ovf
);

    localparam int MIN     = MAC_MIN_WIDTH;
    localparam int MULT    = MAC_MULT_WIDTH;
    localparam int ACC     = MAC_ACC_WIDTH;
    localparam int CONF    = MAC_CONF_WIDTH;
    localparam int CHAIN_W = NUM_MACS * CONF;
    localparam int RES_W   = ACC + 2;

    logic [CHAIN_W-1:0] shadow_q;
    logic [CHAIN_W-1:0] active_q;
    logic               cset_q;

    // A commit has priority over shifting so the copied word is never half-shifted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
            active_q <= '0;
            cset_q   <= 1'b0;
        end else begin
            cset_q <= cset;
            if (cset) begin
                active_q <= shadow_q;
            end else if (cen) begin
                shadow_q <= {shadow_q[CHAIN_W-2:0], shift_in};
            end
        end
    end

    assign shift_out = shadow_q[CHAIN_W-1];
    assign cset_out  = cset_q;

    logic [NUM_MACS*MIN-1:0] a_q;
    logic [NUM_MACS*MIN-1:0] b_q;
    logic                    v1_q;
    logic                    v2_q;
    logic                    out_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q         <= '0;
            b_q         <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            if (in_valid) begin
                a_q <= A;
                b_q <= B;
            end
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
        end
    end

    assign out_valid = out_valid_q;

    logic [MULT-1:0] lane_p [NUM_MACS];

    for (genvar i = 0; i < NUM_MACS; i++) begin : g_lane
        localparam int PREV = (i == 0) ? 0 : i - 1;

        logic             cfg_acc;
        logic             cfg_sgn;
        logic             cfg_casc;
        logic             cfg_sat;
        logic [MIN-1:0]   a_i;
        logic [MIN-1:0]   b_i;
        logic [MULT-1:0]  a_x;
        logic [MULT-1:0]  b_x;
        logic [MULT-1:0]  prod_d;
        logic [MULT-1:0]  p_q;
        logic [RES_W-1:0] ext_p;
        logic [RES_W-1:0] ext_prev;
        logic [RES_W-1:0] ext_acc;
        logic [RES_W-1:0] sum;
        logic [RES_W-1:0] res;
        logic [ACC-1:0]   clamp_d;
        logic [ACC-1:0]   acc_d;
        logic [ACC-1:0]   acc_q;
        logic             ovf_d;
        logic             ovf_q;

        assign cfg_acc  = active_q[i*CONF + 0];
        assign cfg_sgn  = active_q[i*CONF + 1];
        assign cfg_casc = active_q[i*CONF + 2];
        assign cfg_sat  = active_q[i*CONF + 3];

        assign a_i = a_q[i*MIN +: MIN];
        assign b_i = b_q[i*MIN +: MIN];

        // Operands are pre-extended to product width, so one unsigned multiplier
        // yields the correct low MULT bits for both signed and unsigned modes.
        assign a_x    = {{(MULT-MIN){cfg_sgn & a_i[MIN-1]}}, a_i};
        assign b_x    = {{(MULT-MIN){cfg_sgn & b_i[MIN-1]}}, b_i};
        assign prod_d = a_x * b_x;

        assign lane_p[i] = p_q;

        // The neighbour's product is reinterpreted with this lane's signedness.
        assign ext_p    = {{(RES_W-MULT){cfg_sgn & p_q[MULT-1]}}, p_q};
        assign ext_prev = {{(RES_W-MULT){cfg_sgn & lane_p[PREV][MULT-1]}}, lane_p[PREV]};
        assign ext_acc  = {{2{cfg_sgn & acc_q[ACC-1]}}, acc_q};
        assign sum      = ext_p + ((cfg_casc && (i != 0)) ? ext_prev : '0);
        assign res      = ((cfg_acc && !clr) ? ext_acc : '0) + sum;

        always_comb begin
            ovf_d   = 1'b0;
            clamp_d = '0;
            if (cfg_sgn) begin
                ovf_d   = (res[RES_W-1:ACC-1] != '0) && (res[RES_W-1:ACC-1] != '1);
                clamp_d = res[RES_W-1] ? {1'b1, {(ACC-1){1'b0}}} : {1'b0, {(ACC-1){1'b1}}};
            end else begin
                ovf_d   = (res[RES_W-1:ACC] != '0);
                clamp_d = res[RES_W-1] ? '0 : '1;
            end
            acc_d = (ovf_d && cfg_sat) ? clamp_d : res[ACC-1:0];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                p_q   <= '0;
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (en) begin
                p_q <= prod_d;
                if (clr) begin
                    acc_q <= v2_q ? acc_d : '0;
                    ovf_q <= v2_q & ovf_d;
                end else if (v2_q) begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_q | ovf_d;
                end
            end
        end

        assign out[i*ACC +: ACC] = acc_q;
        assign ovf[i]            = ovf_q;
    end

endmodule

`default_nettype wire
